// File: rtl/packet_sequencer.sv
// packet_sequencer: double-banked frame assembler for trace packet words.
// Words are gathered into fixed-size frames and read out in completion order.
module packet_sequencer #(
  parameter int FRAMEWORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync,
  input  logic        WdAvail,
  input  logic [15:0] PacketWd,
  input  logic        PacketReset,
  output logic        FrAvail,
  output logic [15:0] FrWd,
  output logic        FrLast,
  input  logic        FrRd,
  output logic [7:0]  Overflow
);
  localparam int IW = $clog2(FRAMEWORDS);
  localparam logic [IW-1:0] LAST = IW'(FRAMEWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DISCARD
  } wr_state_t;

  wr_state_t     state, state_nxt;
  logic [IW-1:0] wr_idx, wr_idx_nxt;
  logic [IW-1:0] rd_idx;
  logic          wr_bank, wr_bank_nxt;
  logic          rd_bank;
  logic [1:0]    full, full_nxt;
  logic [15:0]   mem [2][FRAMEWORDS];

  logic we;
  logic set_full;
  logic drop;
  logic rd_fire;
  logic rd_release;
  logic store_ok;

  assign FrAvail    = full[rd_bank];
  assign FrLast     = FrAvail && (rd_idx == LAST);
  assign FrWd       = mem[rd_bank][rd_idx];
  assign rd_fire    = FrRd && FrAvail;
  assign rd_release = rd_fire && FrLast;

  // A full write bank still accepts a frame's first word if the
  // reader is handing that same bank back in this cycle.
  assign store_ok = !full[wr_bank]
                  || (rd_release
                      && (rd_bank == wr_bank)
                      && (wr_idx == '0));

  always_comb begin
    state_nxt   = state;
    wr_idx_nxt  = wr_idx;
    wr_bank_nxt = wr_bank;
    we          = 1'b0;
    set_full    = 1'b0;
    drop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync) begin
          state_nxt  = FILL;
          wr_idx_nxt = '0;
        end
      end
      FILL: begin
        if (!sync) begin
          state_nxt  = IDLE;
          wr_idx_nxt = '0;
        end else if (PacketReset) begin
          wr_idx_nxt = '0;
        end else if (WdAvail) begin
          if (store_ok) begin
            we = 1'b1;
            if (wr_idx == LAST) begin
              set_full    = 1'b1;
              wr_bank_nxt = ~wr_bank;
              wr_idx_nxt  = '0;
            end else begin
              wr_idx_nxt = wr_idx + IW'(1);
            end
          end else if (wr_idx == '0) begin
            state_nxt  = DISCARD;
            wr_idx_nxt = IW'(1);
            drop       = 1'b1;
          end
        end
      end
      DISCARD: begin
        if (!sync) begin
          state_nxt  = IDLE;
          wr_idx_nxt = '0;
        end else if (PacketReset) begin
          state_nxt  = FILL;
          wr_idx_nxt = '0;
        end else if (WdAvail) begin
          if (wr_idx == LAST) begin
            state_nxt  = FILL;
            wr_idx_nxt = '0;
          end else begin
            wr_idx_nxt = wr_idx + IW'(1);
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        wr_idx_nxt = '0;
      end
    endcase
  end

  always_comb begin
    full_nxt = full;
    if (set_full) full_nxt[wr_bank] = 1'b1;
    if (rd_release) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_idx   <= '0;
      rd_idx   <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full     <= '0;
      Overflow <= '0;
    end else begin
      state   <= state_nxt;
      wr_idx  <= wr_idx_nxt;
      wr_bank <= wr_bank_nxt;
      full    <= full_nxt;
      if (drop && (Overflow != 8'hFF)) begin
        Overflow <= Overflow + 8'd1;
      end
      if (rd_fire) begin
        if (FrLast) begin
          rd_idx  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + IW'(1);
        end
      end
    end
  end

  // Frame storage carries no reset; full flags gate visibility.
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_idx] <= PacketWd;
  end

endmodule

// File: tb/tb_packet_sequencer.sv
// tb_packet_sequencer: directed and random stimulus against a
// frame-queue reference model of the packet sequencer.
module tb_packet_sequencer;
  localparam int FW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync;
  logic        WdAvail;
  logic [15:0] PacketWd;
  logic        PacketReset;
  logic        FrAvail;
  logic [15:0] FrWd;
  logic        FrLast;
  logic        FrRd;
  logic [7:0]  Overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  packet_sequencer #(.FRAMEWORDS(FW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sync        (sync),
    .WdAvail     (WdAvail),
    .PacketWd    (PacketWd),
    .PacketReset (PacketReset),
    .FrAvail     (FrAvail),
    .FrWd        (FrWd),
    .FrLast      (FrLast),
    .FrRd        (FrRd),
    .Overflow    (Overflow)
  );

  // Model: stored words in completion order, plus the frame being built.
  logic [15:0] fq[$];
  logic [15:0] part[$];
  int nfr   = 0;
  int rpos  = 0;
  int mmode = 0;
  int dcnt  = 0;
  int movf  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(bit r, bit s, bit w, logic [15:0] d,
                            bit pr, bit rd);
    if (r) begin
      fq.delete();
      part.delete();
      nfr   = 0;
      rpos  = 0;
      mmode = 0;
      dcnt  = 0;
      movf  = 0;
      return;
    end
    if (rd && nfr > 0) begin
      void'(fq.pop_front());
      if (rpos == FW - 1) begin
        rpos = 0;
        nfr--;
      end else begin
        rpos++;
      end
    end
    case (mmode)
      0: begin
        if (s) begin
          mmode = 1;
          part.delete();
        end
      end
      1: begin
        if (!s) begin
          mmode = 0;
          part.delete();
        end else if (pr) begin
          part.delete();
        end else if (w) begin
          if (part.size() == 0 && nfr >= 2) begin
            mmode = 2;
            dcnt  = 1;
            if (movf < 255) movf++;
          end else begin
            part.push_back(d);
            if (part.size() == FW) begin
              foreach (part[k]) fq.push_back(part[k]);
              nfr++;
              part.delete();
            end
          end
        end
      end
      default: begin
        if (!s) begin
          mmode = 0;
        end else if (pr) begin
          mmode = 1;
        end else if (w) begin
          dcnt++;
          if (dcnt == FW) mmode = 1;
        end
      end
    endcase
  endtask

  task automatic compare();
    check("avail", 32'(FrAvail), 32'(nfr > 0));
    check("last", 32'(FrLast), 32'(nfr > 0 && rpos == FW - 1));
    if (nfr > 0) check("word", 32'(FrWd), 32'(fq[0]));
    check("ovf", 32'(Overflow), 32'(movf));
  endtask

  task automatic cyc(bit r, bit s, bit w, logic [15:0] d,
                     bit pr, bit rd);
    rst         = r;
    sync        = s;
    WdAvail     = w;
    PacketWd    = d;
    PacketReset = pr;
    FrRd        = rd;
    model_step(r, s, w, d, pr, rd);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic words(logic [15:0] base, int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b1, base + 16'(i), 1'b0, 1'b0);
    end
  endtask

  task automatic reads(int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    logic r, s, w, pr, rd;
    int rdp;

    do_reset();
    check("rst_avail", 32'(FrAvail), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);

    words(16'h0001, FW);
    check("single_avail", 32'(FrAvail), 32'd1);
    check("single_first", 32'(FrWd), 32'h0001);
    reads(FW);
    check("single_done", 32'(FrAvail), 32'd0);

    do_reset();
    words(16'h0001, 3 * FW);
    check("drop_ovf", 32'(Overflow), 32'd1);
    reads(FW);
    check("drop_f2_head", 32'(FrWd), 32'(FW + 1));
    reads(FW);
    check("drop_empty", 32'(FrAvail), 32'd0);
    words(16'h0100, FW);
    check("recov_head", 32'(FrWd), 32'h0100);
    reads(FW);

    do_reset();
    words(16'h0050, 5);
    cyc(1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0);
    words(16'hA000, FW);
    check("prst_head", 32'(FrWd), 32'hA000);
    reads(FW);
    check("prst_ovf", 32'(Overflow), 32'd0);

    do_reset();
    words(16'h0010, FW);
    words(16'h0030, 3);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    words(16'h0020, FW);
    reads(FW);
    check("resync_head", 32'(FrWd), 32'h0020);
    reads(FW);
    words(16'h0200, 2 * FW);
    reads(FW - 1);
    check("rel_last", 32'(FrLast), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0055, 1'b0, 1'b1);
    check("rel_ovf", 32'(Overflow), 32'd0);
    words(16'h0056, FW - 1);
    reads(2 * FW);
    check("rel_empty", 32'(FrAvail), 32'd0);

    do_reset();
    words(16'h1000, (2 + 257) * FW);
    check("ovf_sat", 32'(Overflow), 32'd255);
    reads(2 * FW);

    rdp = 5;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rdp = $urandom_range(0, 10);
      r  = ($urandom_range(0, 599) == 0);
      s  = ($urandom_range(0, 79) != 0);
      w  = ($urandom_range(0, 9) < 6);
      pr = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 9) < rdp);
      cyc(r, s, w, 16'($urandom), pr, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_sequencer.md
PACKET_SEQUENCER -- requirements
Module: packet_sequencer

Interface
REQ-001 Parameter FRAMEWORDS, default 8: number of 16-bit words per frame; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 sync  input  1  trace-link-in-sync indicator, already in the clk domain.
REQ-005 WdAvail  input  1  single-cycle strobe; PacketWd is valid this cycle.
REQ-006 PacketWd  input  16  next trace packet word.
REQ-007 PacketReset  input  1  single-cycle strobe; discard any partial frame.
REQ-008 FrAvail  output  1  a complete frame is readable; FrWd is valid.
REQ-009 FrWd  output  16  current read word of the frame at the head.
REQ-010 FrLast  output  1  FrWd is the final word of its frame.
REQ-011 FrRd  input  1  reader accepts FrWd this cycle.
REQ-012 Overflow  output  8  saturating count of frames dropped because no bank was free.

Function
REQ-013 Storage: two banks of FRAMEWORDS x 16; each bank has a full flag; write-bank pointer wrBank; read-bank pointer rdBank; word indexes wrIdx and rdIdx, each log2(FRAMEWORDS) bits wide.
REQ-014 Write FSM states: IDLE, FILL, DISCARD.
- IDLE: ignore WdAvail; go to FILL with wrIdx=0 when sync=1.
REQ-015 FILL, on WdAvail=1:
- write bank not full: store the word at [wrBank][wrIdx] and increment wrIdx.
- word stored at wrIdx=FRAMEWORDS-1: set full[wrBank], toggle wrBank, wrap wrIdx to 0.
REQ-016 FILL, on WdAvail=1 with wrIdx=0 and full[wrBank]=1 (release case in REQ-023 excepted):
- do not store the word; go to DISCARD; set wrIdx=1.
- increment Overflow by 1, saturating at 255.
REQ-017 DISCARD: count WdAvail words without storing them; when the word at wrIdx=FRAMEWORDS-1 arrives, wrap wrIdx to 0 and return to FILL; frame alignment is preserved.
REQ-018 PacketReset=1 in FILL or DISCARD:
- wrIdx <= 0; go to FILL.
- the partial write bank is abandoned; full flags are unchanged.
- PacketReset takes priority over a coincident WdAvail; that word is dropped.
REQ-019 sync=0 in FILL or DISCARD: go to IDLE; wrIdx <= 0; full banks stay readable.
REQ-020 Read side:
- FrAvail = full[rdBank].
- FrWd = bank[rdBank][rdIdx], combinational from registered state.
- FrLast = FrAvail AND (rdIdx = FRAMEWORDS-1).
REQ-021 FrRd=1 with FrAvail=1: increment rdIdx; if FrLast=1, clear full[rdBank], toggle rdBank, wrap rdIdx to 0.
REQ-022 FrRd=1 with FrAvail=0: ignored; no state change.
REQ-023 Simultaneous release and write: if the reader releases bank B (FrLast accepted) in the same cycle the first word of a frame targets bank B, the word is stored, no overflow is counted, and full[B] is cleared.
REQ-024 Completion and release on different banks in the same cycle: both updates take effect independently.
REQ-025 Latency: a frame completed on cycle N (last word WdAvail) gives FrAvail=1 on cycle N+1.
REQ-026 Ordering: frames are read in the order completed; no word of a stored frame is reordered, lost or duplicated.

Reset
REQ-027 On rst=1 the block SHALL set:
- write FSM = IDLE; wrIdx = rdIdx = 0; wrBank = rdBank = 0.
- both full flags = 0; Overflow = 0.
- consequently FrAvail = 0 and FrLast = 0 on the following cycle.
REQ-028 Bank contents are not reset, so FrWd is don't-care while FrAvail=0.
REQ-029 rst asserted mid-frame or mid-read discards all buffered data, with no partial output afterwards.

Verification
REQ-030 Single frame: sync=1, 8 words 0x0001..0x0008 back-to-back, then FrRd held 1 -> FrAvail rises 1 cycle after the 8th word; FrWd outputs 0x0001..0x0008; FrLast=1 only on 0x0008; FrAvail=0 afterwards.
REQ-031 Overflow: 24 words with FrRd=0 -> two frames buffered, third frame dropped, Overflow=1; reading then yields words 1..16 only.
REQ-032 Recovery after a drop: after REQ-031, drain both frames, then send 8 words 0x0100..0x0107 -> stored and read intact, proving DISCARD ended on the frame boundary.
REQ-033 PacketReset: 5 words, PacketReset, then 8 words 0xA000..0xA007 -> single frame 0xA000..0xA007; Overflow=0.
REQ-034 Sync loss and release: one frame full, 3 words, sync=0, sync=1, 8 more words -> first frame intact, second frame equals the post-resync words; then fill both banks and release the last word in the same cycle a new frame's first word arrives -> word stored, Overflow unchanged.
